alu_issue_ctrl: RTL and testbench

- Upstream issue/writeback controller for the 8-bit ALU.
- Accepts one decoded instruction per handshake and holds an 8x8 register file.
- Drives the ALU operand and control inputs for one cycle, then captures the ALU result and flags one cycle later.
- Writes the result back to the register file and holds the architectural carry/zero flags; a 3-state FSM sequences every instruction.

---
 rtl/alu_issue_ctrl_if.sv | 24 ++
 rtl/alu_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU operand/result bus between the issue controller and its neighbours.
// master drives instructions and ALU results (upstream + ALU side); slave is the controller.
interface alu_issue_ctrl_if;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [16:0] instr_i;
    logic        en_alu_o;
    logic [4:0]  aluop_o;
    logic [7:0]  rd_data_o;
    logic [7:0]  ra_data_o;
    logic [7:0]  alu_out_i;
    logic        alu_cy_i;
    logic        alu_zy_i;

    modport master (
        output instr_valid_i, instr_i, alu_out_i, alu_cy_i, alu_zy_i,
        input  instr_ready_o, en_alu_o, aluop_o, rd_data_o, ra_data_o
    );

    modport slave (
        input  instr_valid_i, instr_i, alu_out_i, alu_cy_i, alu_zy_i,
        output instr_ready_o, en_alu_o, aluop_o, rd_data_o, ra_data_o
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 8-bit ALU with an 8x8 register file; ZERO_REG_EN makes r0 read-only zero.
// Latency: accept T, ALU samples T+1, writeback/flags T+2, done_o high the following cycle; ready only in IDLE (one instr per 3 cycles).
module alu_issue_ctrl #(
    parameter int          NREG  = 8,
    parameter logic [4:0]  CP_OP = 5'b01011
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus,
    output logic             flag_c_o,
    output logic             flag_z_o,
    output logic             done_o,
    input  logic [2:0]       dbg_addr_i,
    output logic [7:0]       dbg_data_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_rf [NREG];
    logic [2:0] r_rd_idx;
    logic [4:0] r_aluop;
    logic [7:0] r_rd_data;
    logic [7:0] r_ra_data;
    logic       r_en_alu;
    logic       r_flag_c;
    logic       r_flag_z;
    logic       r_done;

    logic       w_imm_sel;
    logic [4:0] w_op;
    logic [2:0] w_rd;
    logic [2:0] w_ra;
    logic [7:0] w_imm;
    logic       w_accept;
    logic       w_wr_en;
    logic [7:0] w_rd_val;
    logic [7:0] w_ra_val;
    logic [7:0] w_dbg_val;

    assign w_imm_sel = bus.instr_i[16];
    assign w_op      = bus.instr_i[15:11];
    assign w_rd      = bus.instr_i[10:8];
    assign w_imm     = bus.instr_i[7:0];
    assign w_ra      = bus.instr_i[2:0];

    assign w_accept  = (r_state == S_IDLE) && bus.instr_valid_i;

`ifdef ZERO_REG_EN
    assign w_wr_en   = (r_state == S_WB) && (r_aluop != CP_OP) && (r_rd_idx != 3'd0);

    always_comb begin
        w_rd_val  = (w_rd == 3'd0)       ? 8'h00 : r_rf[w_rd];
        w_ra_val  = (w_ra == 3'd0)       ? 8'h00 : r_rf[w_ra];
        w_dbg_val = (dbg_addr_i == 3'd0) ? 8'h00 : r_rf[dbg_addr_i];
    end
`else
    assign w_wr_en   = (r_state == S_WB) && (r_aluop != CP_OP);

    always_comb begin
        w_rd_val  = r_rf[w_rd];
        w_ra_val  = r_rf[w_ra];
        w_dbg_val = r_rf[dbg_addr_i];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rd_idx  <= 3'd0;
            r_aluop   <= 5'd0;
            r_rd_data <= 8'h00;
            r_ra_data <= 8'h00;
            r_en_alu  <= 1'b0;
            r_flag_c  <= 1'b0;
            r_flag_z  <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= 8'h00;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_aluop   <= w_op;
                        r_rd_idx  <= w_rd;
                        r_rd_data <= w_rd_val;
                        r_ra_data <= w_imm_sel ? w_imm : w_ra_val;
                        r_en_alu  <= 1'b1;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_en_alu <= 1'b0;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    // ALU result registered at the end of EXEC is stable here
                    r_flag_c <= bus.alu_cy_i;
                    r_flag_z <= bus.alu_zy_i;
                    if (w_wr_en) begin
                        r_rf[r_rd_idx] <= bus.alu_out_i;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_en_alu <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready_o = (r_state == S_IDLE);
    assign bus.en_alu_o      = r_en_alu;
    assign bus.aluop_o       = r_aluop;
    assign bus.rd_data_o     = r_rd_data;
    assign bus.ra_data_o     = r_ra_data;
    assign flag_c_o          = r_flag_c;
    assign flag_z_o          = r_flag_z;
    assign done_o            = r_done;
    assign dbg_data_o        = w_dbg_val;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU that registers its result on en_alu_o.
module tb_alu_issue_ctrl;

    localparam logic [4:0] OP_MOV = 5'b11110;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00011;
    localparam logic [4:0] OP_CP  = 5'b01011;
    localparam logic [4:0] OP_UND = 5'b00111;

    logic       clk;
    logic       rst_n;
    logic       flag_c;
    logic       flag_z;
    logic       done;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int total = 0;
    int bad   = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .flag_c_o   (flag_c),
        .flag_z_o   (flag_z),
        .done_o     (done),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: samples operands on the edge that closes EXEC
    logic [8:0] alu_t;
    always @(posedge clk) begin
        if (bus.en_alu_o) begin
            case (bus.aluop_o)
                OP_MOV:        alu_t = {1'b0, bus.ra_data_o};
                OP_ADD:        alu_t = {1'b0, bus.rd_data_o} + {1'b0, bus.ra_data_o};
                OP_SUB, OP_CP: alu_t = {1'b0, bus.rd_data_o} - {1'b0, bus.ra_data_o};
                default:       alu_t = 9'd0;
            endcase
            bus.alu_out_i <= alu_t[7:0];
            bus.alu_cy_i  <= alu_t[8];
            bus.alu_zy_i  <= (alu_t[7:0] == 8'h00);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic imm, input logic [4:0] op,
                                       input logic [2:0] rd, input logic [7:0] v);
        return {imm, op, rd, v};
    endfunction

    task automatic rd_reg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
        dbg_addr = idx;
        #1;
        chk(tag, {24'd0, dbg_data}, {24'd0, exp});
    endtask

    // Issues one instruction and checks the EXEC/WB/done timeline; returns at done-high cycle
    task automatic issue(input string tag, input logic [16:0] ins);
        int k;
        k = 0;
        while (!bus.instr_ready_o && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".rdy"}, {31'd0, bus.instr_ready_o}, 32'd1);
        bus.instr_i       = ins;
        bus.instr_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid_i = 1'b0;
        chk({tag, ".en_exec"}, {31'd0, bus.en_alu_o}, 32'd1);
        chk({tag, ".rdy_exec"}, {31'd0, bus.instr_ready_o}, 32'd0);
        chk({tag, ".done_exec"}, {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ".en_wb"}, {31'd0, bus.en_alu_o}, 32'd0);
        chk({tag, ".done_wb"}, {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n_acc;
        int n_en;
        int n_en2;
        logic prev_en;

        rst_n             = 1'b0;
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = '0;
        dbg_addr          = 3'd0;

        // Reset state
        #2;
        chk("rst.en",    {31'd0, bus.en_alu_o}, 32'd0);
        chk("rst.aluop", {27'd0, bus.aluop_o}, 32'd0);
        chk("rst.rd",    {24'd0, bus.rd_data_o}, 32'd0);
        chk("rst.ra",    {24'd0, bus.ra_data_o}, 32'd0);
        chk("rst.fc",    {31'd0, flag_c}, 32'd0);
        chk("rst.fz",    {31'd0, flag_z}, 32'd0);
        chk("rst.done",  {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.rdy", {31'd0, bus.instr_ready_o}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            rd_reg("rst.rf", i[2:0], 8'h00);
        end

        // Load and add with carry out
        issue("mov1", mk(1'b1, OP_MOV, 3'd1, 8'hF0));
        issue("mov2", mk(1'b1, OP_MOV, 3'd2, 8'h20));
        issue("add",  mk(1'b0, OP_ADD, 3'd1, 8'h02));
        chk("add.rd_op", {24'd0, bus.rd_data_o}, 32'hF0);
        chk("add.ra_op", {24'd0, bus.ra_data_o}, 32'h20);
        chk("add.aluop", {27'd0, bus.aluop_o}, {27'd0, OP_ADD});
        rd_reg("add.r1", 3'd1, 8'h10);
        rd_reg("add.r2", 3'd2, 8'h20);
        chk("add.fc", {31'd0, flag_c}, 32'd1);
        chk("add.fz", {31'd0, flag_z}, 32'd0);
        @(posedge clk); #1;
        chk("add.done_end", {31'd0, done}, 32'd0);

        // Zero result
        issue("mov3", mk(1'b1, OP_MOV, 3'd3, 8'h05));
        issue("sub",  mk(1'b1, OP_SUB, 3'd3, 8'h05));
        rd_reg("sub.r3", 3'd3, 8'h00);
        chk("sub.fz", {31'd0, flag_z}, 32'd1);
        chk("sub.fc", {31'd0, flag_c}, 32'd0);

        // Compare: flags only
        issue("cp", mk(1'b1, OP_CP, 3'd1, 8'h22));
        chk("cp.fc", {31'd0, flag_c}, 32'd1);
        chk("cp.fz", {31'd0, flag_z}, 32'd0);
        rd_reg("cp.r1", 3'd1, 8'h10);

        // Undefined opcode writes the ALU result (0)
        issue("mov6", mk(1'b1, OP_MOV, 3'd6, 8'h77));
        rd_reg("mov6.r6", 3'd6, 8'h77);
        issue("und", mk(1'b1, OP_UND, 3'd6, 8'h12));
        rd_reg("und.r6", 3'd6, 8'h00);
        chk("und.fz", {31'd0, flag_z}, 32'd1);

        // Continuous valid: one accept every third cycle
        @(negedge clk);
        bus.instr_i       = mk(1'b1, OP_MOV, 3'd5, 8'h11);
        bus.instr_valid_i = 1'b1;
        n_acc   = 0;
        n_en    = 0;
        n_en2   = 0;
        prev_en = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (bus.instr_ready_o) n_acc++;
            if (bus.en_alu_o) n_en++;
            if (bus.en_alu_o && prev_en) n_en2++;
            prev_en = bus.en_alu_o;
            if (c == 8) bus.instr_valid_i = 1'b0;
            else @(negedge clk);
        end
        chk("cont.accepts", n_acc, 32'd3);
        chk("cont.en_pulses", n_en, 32'd3);
        chk("cont.en_back2back", n_en2, 32'd0);
        @(posedge clk); #1;
        chk("cont.done", {31'd0, done}, 32'd1);
        rd_reg("cont.r5", 3'd5, 8'h11);

        // Reset during WB aborts the instruction
        @(posedge clk); #1;
        bus.instr_i       = mk(1'b1, OP_MOV, 3'd4, 8'hAA);
        bus.instr_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid_i = 1'b0;
        chk("abort.en", {31'd0, bus.en_alu_o}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort.ra",   {24'd0, bus.ra_data_o}, 32'd0);
        chk("abort.fz",   {31'd0, flag_z}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.rdy",  {31'd0, bus.instr_ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort.no_done", {31'd0, done}, 32'd0);
        end
        rd_reg("abort.r4", 3'd4, 8'h00);
        rd_reg("abort.r1", 3'd1, 8'h00);

        // r0 behaviour depends on build option
        issue("mov0", mk(1'b1, OP_MOV, 3'd0, 8'h55));
        chk("mov0.fz", {31'd0, flag_z}, 32'd0);
`ifdef ZERO_REG_EN
        rd_reg("mov0.r0", 3'd0, 8'h00);
`else
        rd_reg("mov0.r0", 3'd0, 8'h55);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
